// File: rtl/universal_shift_reg_n_pkg.sv
// Shared mode and FSM state encodings for the universal shift register slice.
package usr_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SR   = 3'b001,
    MODE_SL   = 3'b010,
    MODE_LOAD = 3'b011,
    MODE_RR   = 3'b100,
    MODE_RL   = 3'b101
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic is_shift_mode(input logic [2:0] m);
    return (m == MODE_SR) || (m == MODE_SL) || (m == MODE_RR) || (m == MODE_RL);
  endfunction

endpackage

// File: rtl/universal_shift_reg_n_dff_bank.sv
// WIDTH-wide register bank with asynchronous active-high clear to RESET_VAL.
module dff_bank #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) q <= RESET_VAL;
    else       q <= d;
  end

endmodule

// File: rtl/universal_shift_reg_n.sv
// Universal shift register: direct hold/shift/rotate/load ops plus a burst
// engine that performs up to WIDTH back-to-back shifts from one start strobe.
module universal_shift_reg_n
  import usr_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int unsigned     CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] par_in,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic             start,
  input  logic [CW-1:0]    cnt_in,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [2:0]      r_dir;
  logic [2:0]      w_dir_nxt;
  logic [CW-1:0]   r_rem;
  logic [CW-1:0]   w_rem_nxt;
  logic            r_done;
  logic            w_done_nxt;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic            w_accept;
  logic [CW-1:0]   w_cnt_sat;

  function automatic logic [WIDTH-1:0] f_apply(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] v,
    input logic             sr,
    input logic             sl,
    input logic [WIDTH-1:0] p
  );
    logic [WIDTH-1:0] res;
    res = v;
    case (m)
      MODE_SR:   res = {sr, v[WIDTH-1:1]};
      MODE_SL:   res = {v[WIDTH-2:0], sl};
      MODE_LOAD: res = p;
      MODE_RR:   res = {v[0], v[WIDTH-1:1]};
      MODE_RL:   res = {v[WIDTH-2:0], v[WIDTH-1]};
      default:   res = v;
    endcase
    return res;
  endfunction

  assign w_accept  = (r_state == ST_IDLE) && start && is_shift_mode(mode);
  assign w_cnt_sat = (cnt_in > CW'(WIDTH)) ? CW'(WIDTH) : cnt_in;

  // The accepting edge only latches the burst; q moves from the following edge.
  always_comb begin
    w_q_nxt = w_q;
    case (r_state)
      ST_IDLE: if (!w_accept && en) w_q_nxt = f_apply(mode, w_q, sin_r, sin_l, par_in);
      ST_RUN:  w_q_nxt = f_apply(r_dir, w_q, sin_r, sin_l, par_in);
      default: w_q_nxt = w_q;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_rem_nxt   = r_rem;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_dir_nxt = mode;
          if (w_cnt_sat == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_RUN;
            w_rem_nxt   = w_cnt_sat;
          end
        end
      end
      ST_RUN: begin
        w_rem_nxt = r_rem - CW'(1);
        if (r_rem == CW'(1)) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state <= ST_IDLE;
      r_dir   <= MODE_HOLD;
      r_rem   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dir   <= w_dir_nxt;
      r_rem   <= w_rem_nxt;
      r_done  <= w_done_nxt;
    end
  end

  dff_bank #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_bank (
    .clk   (clk),
    .clear (clear),
    .d     (w_q_nxt),
    .q     (w_q)
  );

  assign q      = w_q;
  assign sout_r = w_q[0];
  assign sout_l = w_q[WIDTH-1];
  assign busy   = (r_state == ST_RUN);
  assign done   = r_done;

endmodule

// File: tb/tb_universal_shift_reg_n.sv
// Self-checking bench for universal_shift_reg_n (WIDTH=8, RESET_VAL=0).
module tb_universal_shift_reg_n;

  logic       clk = 1'b0;
  logic       clear;
  logic       en;
  logic [2:0] mode;
  logic [7:0] par_in;
  logic       sin_r;
  logic       sin_l;
  logic       start;
  logic [3:0] cnt_in;
  logic [7:0] q;
  logic       sout_r;
  logic       sout_l;
  logic       busy;
  logic       done;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  typedef struct {
    logic [7:0] q;
    logic       busy;
    logic       done;
    string      name;
  } exp_t;

  typedef struct {
    logic       en;
    logic [2:0] mode;
    logic [7:0] par_in;
    logic       sin_r;
    logic       sin_l;
    logic [7:0] exp_q;
    string      name;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[12];

  universal_shift_reg_n #(
    .WIDTH     (8),
    .RESET_VAL (8'h00)
  ) dut (
    .clk    (clk),
    .clear  (clear),
    .en     (en),
    .mode   (mode),
    .par_in (par_in),
    .sin_r  (sin_r),
    .sin_l  (sin_l),
    .start  (start),
    .cnt_in (cnt_in),
    .q      (q),
    .sout_r (sout_r),
    .sout_l (sout_l),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rr8(input logic [7:0] v);
    return {v[0], v[7:1]};
  endfunction

  function automatic logic [7:0] rl8(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input string name, input logic [7:0] eq, input logic eb, input logic ed);
    exp_t e;
    e.q = eq; e.busy = eb; e.done = ed; e.name = name;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_err++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      chk({e.name, ".q"},      q,      e.q);
      chk({e.name, ".sout_r"}, {7'b0, sout_r}, {7'b0, e.q[0]});
      chk({e.name, ".sout_l"}, {7'b0, sout_l}, {7'b0, e.q[7]});
      chk({e.name, ".busy"},   {7'b0, busy},   {7'b0, e.busy});
      chk({e.name, ".done"},   {7'b0, done},   {7'b0, e.done});
    end
  endtask

  task automatic step(input string name, input logic [7:0] eq, input logic eb, input logic ed);
    push_exp(name, eq, eb, ed);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;

    vecs[0]  = '{1'b1, 3'b011, 8'hA5, 1'b0, 1'b0, 8'hA5, "load_a5"};
    vecs[1]  = '{1'b1, 3'b100, 8'h00, 1'b0, 1'b0, 8'hD2, "rr"};
    vecs[2]  = '{1'b1, 3'b101, 8'h00, 1'b0, 1'b0, 8'hA5, "rl"};
    vecs[3]  = '{1'b0, 3'b011, 8'hFF, 1'b0, 1'b0, 8'hA5, "en0_load"};
    vecs[4]  = '{1'b1, 3'b001, 8'h00, 1'b1, 1'b0, 8'hD2, "sr_in1"};
    vecs[5]  = '{1'b1, 3'b010, 8'h00, 1'b0, 1'b0, 8'hA4, "sl_in0"};
    vecs[6]  = '{1'b1, 3'b110, 8'hFF, 1'b1, 1'b1, 8'hA4, "rsv110"};
    vecs[7]  = '{1'b1, 3'b111, 8'hFF, 1'b1, 1'b1, 8'hA4, "rsv111"};
    vecs[8]  = '{1'b1, 3'b000, 8'hFF, 1'b1, 1'b1, 8'hA4, "hold"};
    vecs[9]  = '{1'b1, 3'b001, 8'h00, 1'b0, 1'b1, 8'h52, "sr_in0"};
    vecs[10] = '{1'b1, 3'b010, 8'h00, 1'b0, 1'b1, 8'hA5, "sl_in1"};
    vecs[11] = '{1'b1, 3'b100, 8'h00, 1'b0, 1'b0, 8'hD2, "rr2"};

    clear = 1'b1; en = 1'b0; mode = 3'b000; par_in = 8'h00;
    sin_r = 1'b0; sin_l = 1'b0; start = 1'b0; cnt_in = 4'd0;
    #12;
    push_exp("reset", 8'h00, 1'b0, 1'b0);
    pop_check();
    clear = 1'b0;

    // Test 1: async clear while direct shifting
    en = 1'b1; mode = 3'b001; sin_r = 1'b1;
    step("sr_a", 8'h80, 1'b0, 1'b0);
    step("sr_b", 8'hC0, 1'b0, 1'b0);
    clear = 1'b1;
    #1;
    push_exp("async_clear", 8'h00, 1'b0, 1'b0);
    pop_check();
    #1;
    clear = 1'b0; en = 1'b0; sin_r = 1'b0;

    // Table-driven direct operations
    for (int i = 0; i < 12; i++) begin
      en = vecs[i].en; mode = vecs[i].mode; par_in = vecs[i].par_in;
      sin_r = vecs[i].sin_r; sin_l = vecs[i].sin_l; start = 1'b0;
      step(vecs[i].name, vecs[i].exp_q, 1'b0, 1'b0);
    end

    // Test 3: SL burst of 3 on 0x81 with inputs toggled during RUN
    en = 1'b1; mode = 3'b011; par_in = 8'h81;
    step("load_81", 8'h81, 1'b0, 1'b0);
    en = 1'b0; mode = 3'b010; cnt_in = 4'd3; sin_l = 1'b1; start = 1'b1;
    step("sl3_t0", 8'h81, 1'b1, 1'b0);
    start = 1'b0; mode = 3'b011; en = 1'b1; par_in = 8'hFF;
    step("sl3_t1", 8'h03, 1'b1, 1'b0);
    mode = 3'b100; en = 1'b0; start = 1'b1;
    step("sl3_t2", 8'h07, 1'b1, 1'b0);
    start = 1'b0; mode = 3'b000; en = 1'b1;
    step("sl3_t3", 8'h0F, 1'b0, 1'b1);
    en = 1'b0;
    step("sl3_after", 8'h0F, 1'b0, 1'b0);

    // Test 4: zero-length burst, then start with LOAD acts as a load
    mode = 3'b001; cnt_in = 4'd0; start = 1'b1;
    step("cnt0_t0", 8'h0F, 1'b0, 1'b1);
    start = 1'b0;
    step("cnt0_after", 8'h0F, 1'b0, 1'b0);
    mode = 3'b011; par_in = 8'h3C; en = 1'b1; cnt_in = 4'd3; start = 1'b1;
    step("start_load", 8'h3C, 1'b0, 1'b0);
    start = 1'b0; en = 1'b0;
    step("start_load_after", 8'h3C, 1'b0, 1'b0);

    // Test 5: RR x8 then back-to-back RL with saturated count
    mode = 3'b100; cnt_in = 4'd8; start = 1'b1;
    step("rr8_t0", 8'h3C, 1'b1, 1'b0);
    start = 1'b0;
    v = 8'h3C;
    for (int i = 1; i <= 8; i++) begin
      v = rr8(v);
      step($sformatf("rr8_t%0d", i), v, (i < 8), (i == 8));
    end
    mode = 3'b101; cnt_in = 4'd9; start = 1'b1;
    step("rl_sat_t0", 8'h3C, 1'b1, 1'b0);
    start = 1'b0;
    v = 8'h3C;
    for (int i = 1; i <= 8; i++) begin
      v = rl8(v);
      step($sformatf("rl_sat_t%0d", i), v, (i < 8), (i == 8));
    end

    // Test 6: clear during a 5-shift burst aborts without done
    mode = 3'b001; cnt_in = 4'd5; sin_r = 1'b1; start = 1'b1;
    step("sr5_t0", 8'h3C, 1'b1, 1'b0);
    start = 1'b0;
    step("sr5_t1", 8'h9E, 1'b1, 1'b0);
    #2;
    clear = 1'b1;
    #1;
    push_exp("abort_clear", 8'h00, 1'b0, 1'b0);
    pop_check();
    #1;
    clear = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step($sformatf("abort_idle%0d", i), 8'h00, 1'b0, 1'b0);
    end
    mode = 3'b010; cnt_in = 4'd2; sin_l = 1'b1; start = 1'b1;
    step("sl2_t0", 8'h00, 1'b1, 1'b0);
    start = 1'b0;
    step("sl2_t1", 8'h01, 1'b1, 1'b0);
    step("sl2_t2", 8'h03, 1'b0, 1'b1);
    step("sl2_after", 8'h03, 1'b0, 1'b0);

    if (sb.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
